// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the 4-input round-robin mux scheduler.
package mux_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    // The pointer resets to 3 so the very first search begins at index 0.
    localparam logic [1:0] RR_PTR_RESET = 2'd3;

    // Default number of consecutive cycles an owner may hold the mux while
    // another requester waits.
    localparam int MAX_HOLD_DEFAULT = 4;

    // One-hot decode of a 2-bit requester index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, last
// (mod 4) and returns the first index whose request bit is set.
module rr_pick_4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand_s;

    // Walk the four positions in rotated priority order, first hit wins.
    always_comb begin
        idx    = last;
        any    = 1'b0;
        cand_s = last;
        for (int k = 1; k <= 4; k++) begin
            cand_s = last + 2'(k);
            if (!any && req[cand_s]) begin
                idx = cand_s;
                any = 1'b1;
            end else begin
                idx = idx;
                any = any;
            end
        end
    end

endmodule

// File: rtl/mux_4x1_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux among four single-bit requesters.
// A hold counter limits how long one owner keeps the mux while others wait;
// the selected data bit is registered one cycle behind the select.
module mux_4x1_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       in_0,
    input  logic       in_1,
    input  logic       in_2,
    input  logic       in_3,
    output logic [1:0] select,
    output logic [3:0] grant,
    output logic       valid,
    output logic       mux_out,
    output logic       out_valid
);

    // Saturation value of the hold counter (last cycle an owner may keep
    // the mux while someone else is waiting).
    localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(MAX_HOLD - 1);

    sched_state_e     state_r;
    sched_state_e     state_nxt_s;
    logic [1:0]       select_r;
    logic [1:0]       select_nxt_s;
    logic [3:0]       grant_r;
    logic [3:0]       grant_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic [CNT_W-1:0] hold_r;
    logic [CNT_W-1:0] hold_nxt_s;
    logic [1:0]       last_r;
    logic [1:0]       last_nxt_s;
    logic             mux_out_r;
    logic             out_valid_r;

    logic [3:0]       others_s;
    logic [3:0]       pick_req_s;
    logic [1:0]       pick_idx_s;
    logic             pick_any_s;
    logic             data_s;

    // Requests from everyone but the owner; in IDLE the whole req vector is
    // searched, in GRANT only the competitors.
    always_comb begin
        others_s   = req & ~onehot4(select_r);
        pick_req_s = req;
        if (state_r == GRANT) begin
            pick_req_s = others_s;
        end else begin
            pick_req_s = req;
        end
    end

    rr_pick_4 u_pick (
        .req  (pick_req_s),
        .last (last_r),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_nxt_s  = state_r;
        select_nxt_s = select_r;
        grant_nxt_s  = grant_r;
        valid_nxt_s  = valid_r;
        hold_nxt_s   = hold_r;
        last_nxt_s   = last_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s  = GRANT;
                    select_nxt_s = pick_idx_s;
                    grant_nxt_s  = onehot4(pick_idx_s);
                    valid_nxt_s  = 1'b1;
                    last_nxt_s   = pick_idx_s;
                    hold_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    grant_nxt_s = 4'b0000;
                    valid_nxt_s = 1'b0;
                    hold_nxt_s  = {CNT_W{1'b0}};
                end
            end
            GRANT: begin
                if (req[select_r] && ((hold_r < HOLD_LAST_C) || (others_s == 4'b0000))) begin
                    // Owner keeps the mux; counter saturates at the limit.
                    if (hold_r < HOLD_LAST_C) begin
                        hold_nxt_s = hold_r + CNT_W'(1);
                    end else begin
                        hold_nxt_s = hold_r;
                    end
                end else if (others_s != 4'b0000) begin
                    // Hold expired or owner released: hand over with no bubble.
                    select_nxt_s = pick_idx_s;
                    grant_nxt_s  = onehot4(pick_idx_s);
                    valid_nxt_s  = 1'b1;
                    last_nxt_s   = pick_idx_s;
                    hold_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    // Nobody wants the mux; select is left as it was.
                    state_nxt_s = IDLE;
                    grant_nxt_s = 4'b0000;
                    valid_nxt_s = 1'b0;
                    hold_nxt_s  = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = 4'b0000;
                valid_nxt_s = 1'b0;
                hold_nxt_s  = {CNT_W{1'b0}};
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            select_r <= 2'b00;
            grant_r  <= 4'b0000;
            valid_r  <= 1'b0;
            hold_r   <= {CNT_W{1'b0}};
            last_r   <= RR_PTR_RESET;
        end else begin
            state_r  <= state_nxt_s;
            select_r <= select_nxt_s;
            grant_r  <= grant_nxt_s;
            valid_r  <= valid_nxt_s;
            hold_r   <= hold_nxt_s;
            last_r   <= last_nxt_s;
        end
    end

    // The 4:1 data mux driven by the registered select.
    always_comb begin
        data_s = 1'b0;
        case (select_r)
            2'd0:    data_s = in_0;
            2'd1:    data_s = in_1;
            2'd2:    data_s = in_2;
            2'd3:    data_s = in_3;
            default: data_s = 1'b0;
        endcase
    end

    // Registered data output, one cycle behind select; zero when no owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_out_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            mux_out_r   <= valid_r ? data_s : 1'b0;
            out_valid_r <= valid_r;
        end
    end

    assign select    = select_r;
    assign grant     = grant_r;
    assign valid     = valid_r;
    assign mux_out   = mux_out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_4x1_rr_sched.sv
// Directed bench for mux_4x1_rr_sched with a reference model feeding an
// expected-result queue that is drained after every clock edge.
module tb_mux_4x1_rr_sched;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       in_0, in_1, in_2, in_3;
    logic [1:0] select;
    logic [3:0] grant;
    logic       valid;
    logic       mux_out;
    logic       out_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] select;
        logic       valid;
        logic       mux_out;
        logic       out_valid;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic       m_valid;
    logic [1:0] m_sel;
    int         m_last;
    int         m_hold;

    mux_4x1_rr_sched #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_0      (in_0),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .select    (select),
        .grant     (grant),
        .valid     (valid),
        .mux_out   (mux_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int rr(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_sel   = 2'd0;
        m_last  = 3;
        m_hold  = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"},     {4'b0, grant},     8'h00);
        chk({tag, "_select"},    {6'b0, select},    8'h00);
        chk({tag, "_valid"},     {7'b0, valid},     8'h00);
        chk({tag, "_mux_out"},   {7'b0, mux_out},   8'h00);
        chk({tag, "_out_valid"}, {7'b0, out_valid}, 8'h00);
    endtask

    // Drive one cycle of stimulus, predict, wait one edge, compare.
    task automatic step(input logic [3:0] r, input logic [3:0] d);
        exp_t e;
        exp_t g;
        logic [3:0] others;
        int p;
        req = r;
        {in_3, in_2, in_1, in_0} = d;
        e.mux_out   = m_valid ? d[m_sel] : 1'b0;
        e.out_valid = m_valid;
        others = m_valid ? (r & ~(4'b0001 << m_sel)) : r;
        if (!m_valid) begin
            p = rr(r, m_last);
            if (p >= 0) begin
                m_valid = 1'b1; m_sel = 2'(p); m_last = p; m_hold = 0;
            end
        end else if (r[m_sel] && (m_hold < MAX_HOLD - 1 || others == 4'b0000)) begin
            if (m_hold < MAX_HOLD - 1) m_hold = m_hold + 1;
        end else if (others != 4'b0000) begin
            p = rr(others, m_last);
            m_sel = 2'(p); m_last = p; m_hold = 0;
        end else begin
            m_valid = 1'b0; m_hold = 0;
        end
        e.grant  = m_valid ? (4'b0001 << m_sel) : 4'b0000;
        e.select = m_sel;
        e.valid  = m_valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("grant",     {4'b0, grant},     {4'b0, g.grant});
        chk("select",    {6'b0, select},    {6'b0, g.select});
        chk("valid",     {7'b0, valid},     {7'b0, g.valid});
        chk("mux_out",   {7'b0, mux_out},   {7'b0, g.mux_out});
        chk("out_valid", {7'b0, out_valid}, {7'b0, g.out_valid});
    endtask

    // Assert reset between edges, hold it over one edge, release away from edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_async");
        @(posedge clk);
        #1 chk_zero("rst_hold");
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        // 1: reset with all requests and toggling data, before any edge
        rst_n = 1'b0;
        req = 4'b1111;
        {in_3, in_2, in_1, in_0} = 4'b1010;
        model_reset();
        #2 chk_zero("rst_noclk");
        for (int i = 0; i < 3; i++) begin
            {in_3, in_2, in_1, in_0} = ~{in_3, in_2, in_1, in_0};
            @(posedge clk);
            #1 chk_zero("rst_clk");
        end
        #2 rst_n = 1'b1;
        req = 4'b0000;

        // 2: single requester, data latency, release
        step(4'b0010, 4'b0010);
        chk("t2_grant", {4'b0, grant}, 8'h02);
        step(4'b0010, 4'b0010);
        chk("t2_mux_out", {7'b0, mux_out}, 8'h01);
        step(4'b0000, 4'b0010);
        chk("t2_idle", {4'b0, grant}, 8'h00);
        step(4'b0000, 4'b0000);
        chk("t2_ov", {7'b0, out_valid}, 8'h00);

        // 3: all requesting, rotate every MAX_HOLD cycles
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b1111, 4'($urandom_range(0, 15)));
            chk("t3_valid", {7'b0, valid}, 8'h01);
            if (i == 3)  chk("t3_g0", {4'b0, grant}, 8'h01);
            if (i == 4)  chk("t3_g1", {4'b0, grant}, 8'h02);
            if (i == 16) chk("t3_wrap", {4'b0, grant}, 8'h01);
        end

        // 4: lone requester saturates hold, then lower index joins
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b0100, 4'($urandom_range(0, 15)));
        end
        chk("t4_hold", {4'b0, grant}, 8'h04);
        step(4'b0101, 4'b1111);
        chk("t4_switch", {4'b0, grant}, 8'h01);

        // 5: owner drops while others rise, no idle bubble
        step(4'b0001, 4'b0001);
        step(4'b1010, 4'b1010);
        chk("t5_sel", {6'b0, select}, 8'h01);
        step(4'b1000, 4'b0000);
        chk("t5_g3", {4'b0, grant}, 8'h08);
        step(4'b1000, 4'b1000);

        // 6: async reset while granted, restart from reset pointer
        do_reset();
        step(4'b0100, 4'b0100);
        chk("t6_g2", {4'b0, grant}, 8'h04);
        do_reset();
        step(4'b1000, 4'b1000);
        chk("t6_g3", {4'b0, grant}, 8'h08);
        step(4'b1000, 4'b1000);
        chk("t6_data", {7'b0, mux_out}, 8'h01);
        step(4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
